// File: rtl/local_osc_dds_if.sv
// local_osc_dds_if -- stream bundle for the local-oscillator DDS.
//   s_axis_phase_tdata  : phase increment (low PHASE_W bits used)
//   s_axis_phase_tvalid : increment valid / advance enable (no tready)
//   m_axis_data_tvalid  : output sample valid
//   m_axis_data_tdata   : {sine[15:0], cosine[15:0]}, signed
// master drives the phase stream and consumes samples; slave is the DDS.
interface local_osc_dds_if;
  logic [31:0] s_axis_phase_tdata;
  logic        s_axis_phase_tvalid;
  logic        m_axis_data_tvalid;
  logic [31:0] m_axis_data_tdata;

  modport master (
    output s_axis_phase_tdata, s_axis_phase_tvalid,
    input  m_axis_data_tvalid, m_axis_data_tdata
  );

  modport slave (
    input  s_axis_phase_tdata, s_axis_phase_tvalid,
    output m_axis_data_tvalid, m_axis_data_tdata
  );
endinterface

// File: rtl/local_osc_dds.sv
// local_osc_dds -- phase-accumulator DDS with a pipelined CORDIC sin/cos core.
//   aclk  : clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   axis  : local_osc_dds_if.slave (phase increment in, sin/cos samples out)
// Output frequency = increment * f_aclk / 2^PHASE_W. A sample issued in cycle k
// appears in cycle k+LATENCY (LATENCY must be at least 18, the core depth).
module local_osc_dds #(
  parameter int unsigned PHASE_W = 27,
  parameter int unsigned LATENCY = 18
) (
  input  logic           aclk,
  input  logic           reset,
  local_osc_dds_if.slave axis
);
  localparam int unsigned ITER     = 16;
  localparam int unsigned CORE_LAT = ITER + 2;
  localparam int unsigned PAD      = (LATENCY > CORE_LAT) ? LATENCY - CORE_LAT : 0;
  localparam int unsigned GB       = 3;   // guard bits below the output LSB
  localparam int unsigned DW       = 22;
  localparam int unsigned ZW       = 21;  // angle units: 2^20 per full turn

  localparam logic signed [DW-1:0] X_START = 22'sd159184; // 19898 << GB
  localparam logic signed [DW-1:0] RND     = 22'sd4;      // 0.5 LSB at GB=3
  localparam logic signed [DW-1:0] PMAX    = 22'sd32767;
  localparam logic signed [DW-1:0] NMAX    = -22'sd32767;

  // round(atan(2^-i) * 2^20 / (2*pi))
  localparam logic signed [ZW-1:0] ATAN [ITER] = '{
    21'sd131072, 21'sd77376, 21'sd40884, 21'sd20753,
    21'sd10417,  21'sd5213,  21'sd2607,  21'sd1304,
    21'sd652,    21'sd326,   21'sd163,   21'sd81,
    21'sd41,     21'sd20,    21'sd10,    21'sd5
  };

  function automatic logic [15:0] sat16(input logic signed [DW-1:0] v);
    if (v > PMAX) return PMAX[15:0];
    if (v < NMAX) return NMAX[15:0];
    return v[15:0];
  endfunction

  logic                 issue;
  logic [PHASE_W-1:0]   inc;
  logic [PHASE_W-1:0]   acc;
  logic [1:0]           q0;
  logic signed [ZW-1:0] z0;
  logic [LATENCY-1:0]   vsr;

  assign issue = axis.s_axis_phase_tvalid;
  assign inc   = axis.s_axis_phase_tdata[PHASE_W-1:0];

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      q0  <= '0;
      z0  <= '0;
    end else if (issue) begin
      acc <= acc + inc;
      q0  <= acc[PHASE_W-1 -: 2];
      z0  <= {3'b000, acc[PHASE_W-3 -: 18]};
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) vsr <= '0;
    else       vsr <= {vsr[LATENCY-2:0], issue};
  end

  // Residual angle lies in [0, pi/2), inside CORDIC convergence range, so no
  // pre-rotation is needed; the quadrant rides along and is applied at the end.
  for (genvar i = 0; i < ITER; i++) begin : g_rot
    logic signed [DW-1:0] x_in, y_in, x_q, y_q;
    logic signed [ZW-1:0] z_in, z_q;
    logic [1:0]           q_in, q_q;

    if (i == 0) begin : g_first
      assign x_in = X_START;
      assign y_in = '0;
      assign z_in = z0;
      assign q_in = q0;
    end else begin : g_next
      assign x_in = g_rot[i-1].x_q;
      assign y_in = g_rot[i-1].y_q;
      assign z_in = g_rot[i-1].z_q;
      assign q_in = g_rot[i-1].q_q;
    end

    always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
        x_q <= '0;
        y_q <= '0;
        z_q <= '0;
        q_q <= '0;
      end else begin
        q_q <= q_in;
        if (z_in[ZW-1]) begin
          x_q <= x_in + (y_in >>> i);
          y_q <= y_in - (x_in >>> i);
          z_q <= z_in + ATAN[i];
        end else begin
          x_q <= x_in - (y_in >>> i);
          y_q <= y_in + (x_in >>> i);
          z_q <= z_in - ATAN[i];
        end
      end
    end
  end

  logic signed [DW-1:0] xr, yr, c_w, s_w;
  logic [1:0]           qf;
  logic [31:0]          folded, tail, tdata_q;

  assign xr = (g_rot[ITER-1].x_q + RND) >>> GB;
  assign yr = (g_rot[ITER-1].y_q + RND) >>> GB;
  assign qf = g_rot[ITER-1].q_q;

  always_comb begin
    c_w = xr;
    s_w = yr;
    unique case (qf)
      2'd0: begin c_w = xr;  s_w = yr;  end
      2'd1: begin c_w = -yr; s_w = xr;  end
      2'd2: begin c_w = -xr; s_w = -yr; end
      default: begin c_w = yr; s_w = -xr; end
    endcase
  end

  // Saturating after the sign fold keeps -32768 out of both outputs.
  assign folded = {sat16(s_w), sat16(c_w)};

  if (PAD == 0) begin : g_nopad
    assign tail = folded;
  end else begin : g_pad
    logic [31:0] dly [PAD];
    always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
        for (int unsigned j = 0; j < PAD; j++) dly[j] <= '0;
      end else begin
        dly[0] <= folded;
        for (int unsigned j = 1; j < PAD; j++) dly[j] <= dly[j-1];
      end
    end
    assign tail = dly[PAD-1];
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)                tdata_q <= '0;
    else if (vsr[LATENCY-2])  tdata_q <= tail;
  end

  assign axis.m_axis_data_tdata  = tdata_q;
  assign axis.m_axis_data_tvalid = vsr[LATENCY-1];

  logic unused_bits;
  assign unused_bits = ^{axis.s_axis_phase_tdata, g_rot[ITER-1].z_q};
endmodule

// File: tb/tb_local_osc_dds.sv
// tb_local_osc_dds -- directed, table-driven bench for local_osc_dds.
// Each vector is one input cycle {increment, tvalid} with the cosine/sine it
// must produce LAT cycles later; held data is checked during output gaps.
module tb_local_osc_dds;
  localparam int LAT = 18;

  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  local_osc_dds_if bus ();

  local_osc_dds #(.PHASE_W(27), .LATENCY(LAT)) dut (
    .aclk  (aclk),
    .reset (reset),
    .axis  (bus)
  );

  typedef struct {
    logic [31:0] inc;
    logic        v;
    int          ec;
    int          es;
  } vec_t;

  vec_t vec [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_c, last_s;

  // 32767*cos(2*pi*k/16), rounded
  int COS16 [16] = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273,
                     -32767, -30273, -23170, -12539, 0, 12539, 23170, 30273};

  function automatic int sin16(input int k);
    return COS16[(k + 12) % 16];
  endfunction

  task automatic add(input logic [31:0] inc, input logic v, input int ec, input int es);
    vec_t r;
    r.inc = inc; r.v = v; r.ec = ec; r.es = es;
    vec.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d +/-%0d", name, act, exp, tol);
    end
    if (exp == 32767 || exp == -32767) begin
      n_cmp++;
      if (act < -32767 || act > 32767) begin
        n_bad++;
        $display("FAIL %s range: got %0d, want within +/-32767", name, act);
      end
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_bit({tag, " m_tvalid"}, bus.m_axis_data_tvalid, 1'b0);
    n_cmp++;
    if (bus.m_axis_data_tdata !== 32'h0) begin
      n_bad++;
      $display("FAIL %s tdata: got %h, want 00000000", tag, bus.m_axis_data_tdata);
    end
  endtask

  // Assert reset (async), hold it with tvalid=1, release just after an edge.
  task automatic do_reset(input string tag, input int cycles, input logic [31:0] inc);
    bus.s_axis_phase_tdata  = inc;
    bus.s_axis_phase_tvalid = 1'b1;
    reset = 1'b1;
    #1;
    chk_zero({tag, " rst-immediate"});
    repeat (cycles) begin
      @(posedge aclk); #1;
      chk_zero({tag, " rst-held"});
    end
    reset  = 1'b0;
    last_c = 0;
    last_s = 0;
  endtask

  task automatic run_vectors(input string tag);
    int   n, idx;
    logic ev;
    n = vec.size();
    for (int c = 0; c < n + LAT; c++) begin
      if (c < n) begin
        bus.s_axis_phase_tdata  = vec[c].inc;
        bus.s_axis_phase_tvalid = vec[c].v;
      end else begin
        bus.s_axis_phase_tvalid = 1'b0;
      end
      @(posedge aclk); #1;
      idx = c - LAT + 1;
      ev  = (idx >= 0 && idx < n) ? vec[idx].v : 1'b0;
      chk_bit($sformatf("%s m_tvalid c%0d", tag, c), bus.m_axis_data_tvalid, ev);
      if (ev) begin
        last_c = vec[idx].ec;
        last_s = vec[idx].es;
      end
      chk($sformatf("%s cos c%0d", tag, c), $signed(bus.m_axis_data_tdata[15:0]), last_c, 4);
      chk($sformatf("%s sin c%0d", tag, c), $signed(bus.m_axis_data_tdata[31:16]), last_s, 4);
    end
    vec.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_phase_tdata  = '0;
    bus.s_axis_phase_tvalid = 1'b0;
    reset = 1'b1;

    // Reset for 3 cycles with tvalid=1, then quarter-turn steps; upper
    // increment bits set in the second half must be ignored.
    do_reset("A", 3, 32'h0200_0000);
    for (int k = 0; k < 8; k++)
      add((k < 4) ? 32'h0200_0000 : 32'hFA00_0000, 1'b1, COS16[(4*k) % 16], sin16(4*k));
    run_vectors("A");

    // 1 MHz: 16-sample period, two full periods.
    do_reset("B", 2, 32'h0);
    for (int k = 0; k < 32; k++) add(32'h0080_0000, 1'b1, COS16[k % 16], sin16(k));
    run_vectors("B");

    // Negative step 2^27-2^23: phase walks backwards through the wrap.
    do_reset("C", 2, 32'h0);
    for (int k = 0; k < 20; k++)
      add(32'h0780_0000, 1'b1, COS16[(16 - (k % 16)) % 16], sin16((16 - (k % 16)) % 16));
    run_vectors("C");

    // Nyquist.
    do_reset("N", 2, 32'h0);
    for (int k = 0; k < 6; k++) add(32'h0400_0000, 1'b1, (k % 2 == 0) ? 32767 : -32767, 0);
    run_vectors("N");

    // tvalid gaps: phase must freeze while tvalid=0.
    do_reset("D", 2, 32'h0);
    add(32'h0200_0000, 1'b1, 32767, 0);
    add(32'h0200_0000, 1'b1, 0, 32767);
    add(32'h0200_0000, 1'b0, 0, 0);
    add(32'h0200_0000, 1'b0, 0, 0);
    add(32'h0200_0000, 1'b1, -32767, 0);
    add(32'h0200_0000, 1'b1, 0, -32767);
    run_vectors("D");

    // Mid-stream reset at 1 kHz: outputs clear at once, restart from phase 0.
    bus.s_axis_phase_tdata  = 32'd8389;
    bus.s_axis_phase_tvalid = 1'b1;
    repeat (25) @(posedge aclk);
    #1;
    chk_bit("E streaming m_tvalid", bus.m_axis_data_tvalid, 1'b1);
    @(negedge aclk);
    do_reset("E", 2, 32'd8389);
    add(32'd8389, 1'b1, 32767, 0);
    add(32'd8389, 1'b1, 32767, 13);
    add(32'd8389, 1'b1, 32767, 26);
    add(32'd8389, 1'b1, 32767, 39);
    run_vectors("E");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
